// File: rtl/core_mem_initiator_if.sv
// rtl/core_mem_initiator_if.sv - shared memory req/gnt/rvalid bus between a core initiator and the responder
interface core_mem_initiator_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              req;
    logic              gnt;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rvalid;
    logic [3:0]        opcode;
    logic [1:0]        core_id;
    logic [31:0]       burst_id;

    modport master (
        output req, we, addr, data_in, opcode, core_id, burst_id,
        input  gnt, data_out, rvalid
    );

    modport slave (
        input  req, we, addr, data_in, opcode, core_id, burst_id,
        output gnt, data_out, rvalid
    );
endinterface

// File: rtl/core_mem_initiator.sv
// rtl/core_mem_initiator.sv - core-side burst requester with per-beat timeout for the shared memory bus
module core_mem_initiator #(
    parameter int         ADDR_W  = 11,
    parameter int         DATA_W  = 32,
    parameter int         LEN_W   = 4,
    parameter int         TIMEOUT = 15,
    parameter logic [1:0] CORE_ID = 2'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [3:0]        cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_pop,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              done,
    output logic              err,
    core_mem_initiator_if.master bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               we_r;
    logic [3:0]         opcode_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   beat;
    logic [DATA_W-1:0]  data_in_r;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [31:0]        burst_id_r;
    logic               tagged_r;
    logic               accept;
    logic               beat_done;
    logic               last_beat;
    logic               timed_out;

    assign accept    = (state == IDLE) && cmd_valid;
    assign beat_done = (state == WAIT) && (we_r ? bus.gnt : bus.rvalid);
    assign last_beat = (beat == len_r);
    assign timed_out = (state == WAIT) && !beat_done && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (beat_done)      state_nxt = last_beat ? IDLE : ISSUE;
                else if (timed_out) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write data passes straight through during the request cycle and is held afterwards.
    assign cmd_ready    = (state == IDLE);
    assign bus.req      = (state == ISSUE);
    assign wdata_pop    = (state == ISSUE) && we_r;
    assign bus.data_in  = wdata_pop ? wdata : data_in_r;
    assign bus.we       = we_r;
    assign bus.addr     = addr_r;
    assign bus.opcode   = opcode_r;
    assign bus.burst_id = burst_id_r;
    assign bus.core_id  = CORE_ID;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            we_r       <= 1'b0;
            opcode_r   <= '0;
            addr_r     <= '0;
            len_r      <= '0;
            beat       <= '0;
            data_in_r  <= '0;
            tmo_cnt    <= '0;
            burst_id_r <= '0;
            tagged_r   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            if (accept) begin
                we_r     <= cmd_we;
                opcode_r <= cmd_opcode;
                addr_r   <= cmd_addr;
                len_r    <= cmd_len;
                beat     <= '0;
                tagged_r <= 1'b1;
                if (tagged_r) burst_id_r <= burst_id_r + 32'd1;
            end
            if (state == ISSUE) begin
                tmo_cnt <= '0;
                if (we_r) data_in_r <= wdata;
            end
            if ((state == WAIT) && !beat_done) tmo_cnt <= tmo_cnt + 1'b1;
            if (beat_done) begin
                if (!we_r) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= bus.data_out;
                    rsp_last  <= last_beat;
                end
                if (last_beat) begin
                    done <= 1'b1;
                end else begin
                    beat   <= beat + 1'b1;
                    addr_r <= addr_r + 1'b1;
                end
            end
            if (timed_out) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_core_mem_initiator.sv
// tb/tb_core_mem_initiator.sv - randomized self-checking bench for core_mem_initiator
`timescale 1ns/1ps
module tb_core_mem_initiator;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid, cmd_ready, cmd_we;
    logic [3:0]        cmd_opcode;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wdata, rsp_data;
    logic              wdata_pop, rsp_valid, rsp_last, done, err;

    core_mem_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    core_mem_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                         .TIMEOUT(TIMEOUT), .CORE_ID(2'd0)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_pop(wdata_pop),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .done(done), .err(err), .bus(bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [ADDR_W-1:0] addr; logic we; logic [DATA_W-1:0] data;
                    logic [3:0] op; logic [31:0] bid;} req_t;
    typedef struct {int cyc; logic [DATA_W-1:0] data; logic last;} rsp_t;
    typedef struct {int cyc; logic err;} done_t;

    req_t  req_q[$];
    rsp_t  rsp_q[$];
    done_t done_q[$];
    int    pop_cnt;

    logic [DATA_W-1:0] mem     [2**ADDR_W];
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    logic [DATA_W-1:0] wbuf[$];
    int widx;
    int gnt_dly = 1, rv_dly = 1;
    bit silent = 1'b0, resp_busy = 1'b0;
    int accepts = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.req)   req_q.push_back('{cyc, bus.addr, bus.we, bus.data_in, bus.opcode, bus.burst_id});
            if (rsp_valid) rsp_q.push_back('{cyc, rsp_data, rsp_last});
            if (done)      done_q.push_back('{cyc, err});
            if (wdata_pop) pop_cnt++;
        end
    end

    // Responder: one outstanding beat, gnt after gnt_dly cycles, rvalid after rv_dly cycles.
    initial begin : responder
        logic [ADDR_W-1:0] ra;
        logic              rw;
        logic [DATA_W-1:0] rd;
        int                span;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.data_out = '0;
        forever begin
            @(negedge clk);
            if (bus.req && !silent) begin
                ra = bus.addr; rw = bus.we; rd = bus.data_in;
                resp_busy = 1'b1;
                span = rw ? gnt_dly : rv_dly;
                for (int c = 1; c <= span; c++) begin
                    @(posedge clk); #1;
                    bus.gnt      = (c == gnt_dly);
                    bus.rvalid   = !rw && (c == rv_dly);
                    bus.data_out = (!rw && c == rv_dly) ? mem[ra] : DATA_W'($urandom);
                    if (rw && c == gnt_dly) mem[ra] = rd;
                end
                @(posedge clk); #1;
                bus.gnt = 1'b0; bus.rvalid = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end

    initial begin : wdata_driver
        forever begin
            @(negedge clk);
            if (wdata_pop) begin
                @(posedge clk); #1;
                widx++;
                wdata = (widx < wbuf.size()) ? wbuf[widx] : DATA_W'($urandom);
            end
        end
    end

    task automatic fill_wbuf(input int n);
        wbuf.delete();
        for (int i = 0; i < n; i++) wbuf.push_back(DATA_W'($urandom));
    endtask

    task automatic wait_resp_idle();
        int t = 0;
        while (resp_busy && t < 100) begin @(negedge clk); t++; end
    endtask

    // Drives one command and scores it against timing/data rules computed from the beat delays.
    task automatic run_cmd(input logic w, input logic [3:0] op, input logic [ADDR_W-1:0] a,
                           input int len, input int gd, input int rdl, input bit sil);
        int acc, c, n_beats, t, bid, exp_cyc, exp_rsp, exp_pop;
        bit abort;
        logic [ADDR_W-1:0] ba;
        wait_resp_idle();
        gnt_dly = gd; rv_dly = rdl; silent = sil;
        req_q.delete(); rsp_q.delete(); done_q.delete();
        pop_cnt = 0; widx = 0; wdata = wbuf[0];
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_we = w; cmd_opcode = op; cmd_addr = a; cmd_len = LEN_W'(len);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_opcode = 4'($urandom);
        cmd_addr = ADDR_W'($urandom); cmd_len = LEN_W'($urandom);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_busy: got %b want 0", cmd_ready); end
        t = 0;
        while (done_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);

        bid = accepts; accepts++;
        c = w ? gd : rdl;
        abort = sil || (c > TIMEOUT);
        n_beats = abort ? 1 : len + 1;
        checks++;
        if (req_q.size() != n_beats) begin
            errors++; $display("FAIL req_count: got %0d want %0d", req_q.size(), n_beats);
        end
        for (int i = 0; i < n_beats && i < req_q.size(); i++) begin
            ba = a + ADDR_W'(i);
            exp_cyc = acc + 1 + i * (c + 1);
            checks++;
            if (req_q[i].addr !== ba || req_q[i].we !== w || req_q[i].op !== op ||
                req_q[i].bid !== bid || req_q[i].cyc != exp_cyc || (w && req_q[i].data !== wbuf[i])) begin
                errors++;
                $display("FAIL req_beat%0d: got addr=%h we=%b op=%h bid=%0d cyc=%0d data=%h want addr=%h we=%b op=%h bid=%0d cyc=%0d data=%h",
                         i, req_q[i].addr, req_q[i].we, req_q[i].op, req_q[i].bid, req_q[i].cyc, req_q[i].data,
                         ba, w, op, bid, exp_cyc, w ? wbuf[i] : req_q[i].data);
            end
        end
        exp_pop = w ? n_beats : 0;
        checks++;
        if (pop_cnt != exp_pop) begin errors++; $display("FAIL wdata_pop_count: got %0d want %0d", pop_cnt, exp_pop); end
        exp_rsp = (w || abort) ? 0 : n_beats;
        checks++;
        if (rsp_q.size() != exp_rsp) begin errors++; $display("FAIL rsp_count: got %0d want %0d", rsp_q.size(), exp_rsp); end
        for (int i = 0; i < exp_rsp && i < rsp_q.size(); i++) begin
            ba = a + ADDR_W'(i);
            exp_cyc = acc + 1 + i * (c + 1) + c + 1;
            checks++;
            if (rsp_q[i].data !== ref_mem[ba] || rsp_q[i].last !== (i == len) || rsp_q[i].cyc != exp_cyc) begin
                errors++;
                $display("FAIL rsp_beat%0d: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                         i, rsp_q[i].data, rsp_q[i].last, rsp_q[i].cyc, ref_mem[ba], (i == len), exp_cyc);
            end
        end
        exp_cyc = abort ? acc + TIMEOUT + 2 : acc + 1 + len * (c + 1) + c + 1;
        checks++;
        if (done_q.size() != 1) begin
            errors++; $display("FAIL done_count: got %0d want 1", done_q.size());
        end else if (done_q[0].cyc != exp_cyc || done_q[0].err !== abort) begin
            errors++;
            $display("FAIL done_pulse: got cyc=%0d err=%b want cyc=%0d err=%b", done_q[0].cyc, done_q[0].err, exp_cyc, abort);
        end
        if (w && !abort) for (int i = 0; i <= len; i++) ref_mem[a + ADDR_W'(i)] = wbuf[i];
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_opcode = '0; cmd_addr = '0; cmd_len = '0; wdata = '0;
        reset_n = 1'b0;
        #12;
        checks++;
        if ({bus.req, bus.we, wdata_pop, rsp_valid, rsp_last, done, err} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000000", {bus.req, bus.we, wdata_pop, rsp_valid, rsp_last, done, err});
        end
        checks++;
        if (bus.addr !== '0 || bus.data_in !== '0 || bus.opcode !== '0 || rsp_data !== '0 || bus.burst_id !== '0) begin
            errors++; $display("FAIL reset_values: got addr=%h data_in=%h op=%h rsp_data=%h bid=%h want all 0",
                               bus.addr, bus.data_in, bus.opcode, rsp_data, bus.burst_id);
        end
        checks++;
        if (cmd_ready !== 1'b1 || bus.core_id !== 2'd0) begin
            errors++; $display("FAIL reset_ready: got ready=%b core_id=%0d want 1 0", cmd_ready, bus.core_id);
        end
        @(negedge clk); reset_n = 1'b1;
        accepts = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write_read();
        wbuf.delete(); wbuf.push_back(32'hDEADBEEF);
        run_cmd(1'b1, 4'h3, 11'h010, 0, 1, 1, 1'b0);
        fill_wbuf(1);
        run_cmd(1'b0, 4'h2, 11'h010, 0, 1, 1, 1'b0);
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_readback: got n=%0d data=%h want 1 deadbeef",
                               rsp_q.size(), rsp_q.size() ? rsp_q[0].data : 32'h0);
        end
    endtask

    task automatic test_wrap_burst();
        wbuf.delete();
        for (int i = 1; i <= 4; i++) wbuf.push_back(DATA_W'(i));
        run_cmd(1'b1, 4'h7, 11'h7FE, 3, 1, 1, 1'b0);
        fill_wbuf(4);
        run_cmd(1'b0, 4'h6, 11'h7FE, 3, 1, 1, 1'b0);
        checks++;
        if (rsp_q.size() != 4 || rsp_q[2].data !== 32'd3 || req_q[2].addr !== 11'h000) begin
            errors++; $display("FAIL wrap_readback: got n=%0d want 4 with beat2 addr 000 data 3", rsp_q.size());
        end
    endtask

    task automatic test_timeout();
        fill_wbuf(3);
        run_cmd(1'b0, 4'h1, 11'h020, 2, 1, 1, 1'b1);
        fill_wbuf(2);
        run_cmd(1'b1, 4'h9, 11'h030, 1, 1, 1, 1'b1);
        fill_wbuf(2);
        run_cmd(1'b0, 4'h1, 11'h020, 1, 1, 1, 1'b0);
        // last cycle inside the window completes; one later aborts and the late rvalid is ignored
        fill_wbuf(1);
        run_cmd(1'b0, 4'h4, 11'h010, 0, TIMEOUT, TIMEOUT, 1'b0);
        fill_wbuf(1);
        run_cmd(1'b0, 4'h4, 11'h010, 0, TIMEOUT + 1, TIMEOUT + 1, 1'b0);
    endtask

    task automatic test_delayed_read();
        fill_wbuf(3);
        run_cmd(1'b0, 4'h5, 11'h7FE, 2, 1, 2, 1'b0);
        fill_wbuf(2);
        run_cmd(1'b1, 4'hA, 11'h200, 1, 3, 3, 1'b0);
    endtask

    task automatic test_random();
        int len, gd, rdl;
        for (int k = 0; k < 14; k++) begin
            len = $urandom_range(0, 7);
            gd  = $urandom_range(1, 3);
            rdl = gd + $urandom_range(0, 2);
            fill_wbuf(len + 1);
            run_cmd(1'($urandom), 4'($urandom), ADDR_W'($urandom_range(2040, 2055)), len, gd, rdl, 1'b0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int t, nreq;
        wait_resp_idle();
        gnt_dly = 1; rv_dly = 1; silent = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 11'h100; cmd_len = 4'd3; cmd_opcode = 4'h5;
        @(negedge clk);
        cmd_valid = 1'b0;
        nreq = 0; t = 0;
        while (t < 50) begin
            if (bus.req) nreq++;
            if (nreq == 2) break;
            @(negedge clk); t++;
        end
        checks++;
        if (nreq != 2) begin errors++; $display("FAIL mid_reset_reach_beat2: got %0d reqs want 2", nreq); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.req !== 1'b0 || cmd_ready !== 1'b1 || bus.burst_id !== 32'd0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_drop: got req=%b ready=%b bid=%0d done=%b want 0 1 0 0",
                               bus.req, cmd_ready, bus.burst_id, done);
        end
        accepts = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        req_q.delete(); rsp_q.delete(); done_q.delete();
        repeat (6) @(negedge clk);
        checks++;
        if (done_q.size() != 0 || rsp_q.size() != 0 || req_q.size() != 0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_quiet: got done=%0d rsp=%0d req=%0d ready=%b want 0 0 0 1",
                               done_q.size(), rsp_q.size(), req_q.size(), cmd_ready);
        end
        fill_wbuf(2);
        run_cmd(1'b0, 4'h5, 11'h100, 1, 1, 1, 1'b0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            mem[i] = DATA_W'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_single_write_read();
        test_wrap_burst();
        test_timeout();
        test_delayed_read();
        test_random();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
